// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer
//
// Frame-synchronous scroll-offset controller for the diagonal-line animation
// renderer. The horizontal offset advances only on vertical-blank pulses, so a
// displayed frame never tears. A small command port runs, pauses, single-steps
// or rewinds the animation.
//
// Optional feature: define ANIM_PINGPONG_EN to make the offset bounce between
// 0 and H_DISPLAY-1 instead of wrapping. Without the macro the offset wraps and
// no direction register exists.
//
// Ports:
//   clk_i          pixel clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   vblank_start_i one-cycle pulse at the first non-display line
//   cmd_valid_i    command request
//   cmd_op_i       00 RUN, 01 PAUSE, 10 SINGLE_STEP, 11 REWIND
//   cmd_ready_o    command accepted when cmd_valid_i && cmd_ready_o
//   offset_o       current scroll offset, 0..H_DISPLAY-1
//   offset_upd_o   one-cycle pulse when the offset changes value or direction
//   running_o      high in the RUN state
//   frame_cnt_o    blank pulses since reset, wrapping
module anim_frame_sequencer #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vblank_start_i,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_op_i,
  output logic        cmd_ready_o,
  output logic [9:0]  offset_o,
  output logic        offset_upd_o,
  output logic        running_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(FRAME_DIV - 1);
  localparam logic [10:0] HDisp = 11'(H_DISPLAY);
  localparam logic [10:0] StepW = 11'(STEP);

  localparam logic [1:0] OpRun    = 2'b00;
  localparam logic [1:0] OpPause  = 2'b01;
  localparam logic [1:0] OpStep   = 2'b10;
  localparam logic [1:0] OpRewind = 2'b11;

  typedef enum logic [1:0] {
    StPaused   = 2'd0,
    StRun      = 2'd1,
    StStepPend = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      offset_q, offset_d;
  logic [DivW-1:0] div_q, div_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            upd_q, upd_d;

  logic            cmd_acc;
  logic            advance;
  logic [10:0]     sum;
  logic [9:0]      adv_off;

`ifdef ANIM_PINGPONG_EN
  localparam logic [10:0] HTop2 = 11'(2 * (H_DISPLAY - 1));

  logic              dir_q, dir_d;
  logic              adv_dir;
  logic signed [11:0] diff;

  // Reflect off the top or bottom edge; direction flips only on an overshoot.
  always_comb begin
    sum     = {1'b0, offset_q} + StepW;
    diff    = $signed({2'b00, offset_q}) - $signed({1'b0, StepW});
    adv_off = offset_q;
    adv_dir = dir_q;
    if (!dir_q) begin
      if (sum > HDisp - 11'd1) begin
        adv_off = 10'(HTop2 - sum);
        adv_dir = 1'b1;
      end else begin
        adv_off = sum[9:0];
      end
    end else begin
      if (diff < 0) begin
        adv_off = 10'(-diff);
        adv_dir = 1'b0;
      end else begin
        adv_off = diff[9:0];
      end
    end
  end
`else
  always_comb begin
    sum     = {1'b0, offset_q} + StepW;
    adv_off = (sum >= HDisp) ? 10'(sum - HDisp) : sum[9:0];
  end
`endif

  assign cmd_ready_o = !rst_i && (state_q != StStepPend);
  assign cmd_acc     = cmd_valid_i && cmd_ready_o;

  // Blank pulse is evaluated against the current state first; an accepted
  // command then overrides the next state (and REWIND overrides any advance).
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    div_d       = div_q;
    frame_cnt_d = frame_cnt_q + 16'(vblank_start_i);
    advance     = 1'b0;
`ifdef ANIM_PINGPONG_EN
    dir_d       = dir_q;
`endif

    if (vblank_start_i) begin
      unique case (state_q)
        StRun: begin
          if (div_q == DivMax) begin
            div_d   = '0;
            advance = 1'b1;
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
        StStepPend: begin
          advance = 1'b1;
          state_d = StPaused;
        end
        default: ;
      endcase
    end

    if (advance) begin
      offset_d = adv_off;
`ifdef ANIM_PINGPONG_EN
      dir_d    = adv_dir;
`endif
    end

    if (cmd_acc) begin
      unique case (cmd_op_i)
        OpRun: begin
          if (state_q != StRun) begin
            state_d = StRun;
            div_d   = '0;
          end
        end
        OpPause:  state_d = StPaused;
        OpStep:   state_d = StStepPend;
        OpRewind: begin
          offset_d = '0;
          div_d    = '0;
`ifdef ANIM_PINGPONG_EN
          dir_d    = 1'b0;
`endif
        end
        default: ;
      endcase
    end

`ifdef ANIM_PINGPONG_EN
    upd_d = (offset_d != offset_q) || (dir_d != dir_q);
`else
    upd_d = (offset_d != offset_q);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StPaused;
      offset_q    <= '0;
      div_q       <= '0;
      frame_cnt_q <= '0;
      upd_q       <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      upd_q       <= upd_d;
`ifdef ANIM_PINGPONG_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign offset_o     = offset_q;
  assign offset_upd_o = upd_q;
  assign running_o    = (state_q == StRun);
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer. Instance 0 uses STEP=1,
// FRAME_DIV=2; instance 1 uses STEP=7, FRAME_DIV=1 to exercise the edge case
// at the top of the offset range. Each instance has its own stimulus inputs.
module tb_anim_frame_sequencer;

  localparam logic [1:0] OpRun    = 2'b00;
  localparam logic [1:0] OpPause  = 2'b01;
  localparam logic [1:0] OpStep   = 2'b10;
  localparam logic [1:0] OpRewind = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank    [2];
  logic        cmd_valid [2];
  logic [1:0]  cmd_op    [2];
  logic        cmd_ready [2];
  logic [9:0]  offset    [2];
  logic        upd       [2];
  logic        running   [2];
  logic [15:0] frame_cnt [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  anim_frame_sequencer #(.H_DISPLAY(640), .STEP(1), .FRAME_DIV(2)) u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .vblank_start_i (vblank[0]),
    .cmd_valid_i    (cmd_valid[0]),
    .cmd_op_i       (cmd_op[0]),
    .cmd_ready_o    (cmd_ready[0]),
    .offset_o       (offset[0]),
    .offset_upd_o   (upd[0]),
    .running_o      (running[0]),
    .frame_cnt_o    (frame_cnt[0])
  );

  anim_frame_sequencer #(.H_DISPLAY(640), .STEP(7), .FRAME_DIV(1)) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .vblank_start_i (vblank[1]),
    .cmd_valid_i    (cmd_valid[1]),
    .cmd_op_i       (cmd_op[1]),
    .cmd_ready_o    (cmd_ready[1]),
    .offset_o       (offset[1]),
    .offset_upd_o   (upd[1]),
    .running_o      (running[1]),
    .frame_cnt_o    (frame_cnt[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int sel);
    vblank[sel] = 1'b1;
    tick();
    vblank[sel] = 1'b0;
  endtask

  task automatic command(input int sel, input logic [1:0] op);
    cmd_valid[sel] = 1'b1;
    cmd_op[sel]    = op;
    tick();
    cmd_valid[sel] = 1'b0;
  endtask

`ifdef ANIM_PINGPONG_EN
  localparam int BRuns  = 91;   // 91*7 = 637, no bounce yet
  localparam int BStart = 637;
  localparam int BTop   = 634;  // 1278 - 644, direction now down
  localparam int BNext  = 627;
`else
  localparam int BRuns  = 548;  // 548*7 = 3836 = 5*640 + 636
  localparam int BStart = 636;
  localparam int BTop   = 3;    // 643 - 640
  localparam int BNext  = 10;
`endif

  initial begin
    for (int s = 0; s < 2; s++) begin
      vblank[s]    = 1'b0;
      cmd_valid[s] = 1'b0;
      cmd_op[s]    = 2'b00;
    end
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check_eq("rst_ready_a", 32'(cmd_ready[0]), 32'd0);
    check_eq("rst_ready_b", 32'(cmd_ready[1]), 32'd0);
    check_eq("rst_offset", 32'(offset[0]), 32'd0);
    check_eq("rst_upd", 32'(upd[0]), 32'd0);
    check_eq("rst_running", 32'(running[0]), 32'd0);
    check_eq("rst_frame_cnt", 32'(frame_cnt[0]), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'(cmd_ready[0]), 32'd1);

    // Pulses while paused: counted, no advance
    for (int i = 0; i < 3; i++) begin
      pulse(0);
      check_eq("paused_upd", 32'(upd[0]), 32'd0);
      check_eq("paused_offset", 32'(offset[0]), 32'd0);
    end
    check_eq("paused_frame_cnt", 32'(frame_cnt[0]), 32'd3);

    // Wrap (or bounce) at the top of the range, instance 1
    command(1, OpRun);
    check_eq("b_running", 32'(running[1]), 32'd1);
    for (int i = 0; i < BRuns; i++) pulse(1);
    check_eq("b_offset_start", 32'(offset[1]), 32'(BStart));
    pulse(1);
    check_eq("b_offset_top", 32'(offset[1]), 32'(BTop));
    check_eq("b_upd_top", 32'(upd[1]), 32'd1);
    pulse(1);
    check_eq("b_offset_next", 32'(offset[1]), 32'(BNext));
    check_eq("b_frame_cnt", 32'(frame_cnt[1]), 32'(BRuns + 2));

    // RUN with divide-by-2
    command(0, OpRun);
    check_eq("run_running", 32'(running[0]), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      pulse(0);
      check_eq("div_upd", 32'(upd[0]), 32'((i % 2) == 0));
      check_eq("div_offset", 32'(offset[0]), 32'(i / 2));
    end
    tick();
    check_eq("div_upd_idle", 32'(upd[0]), 32'd0);
    check_eq("div_frame_cnt", 32'(frame_cnt[0]), 32'd9);

    // Single step with a RUN held off by cmd_ready
    command(0, OpPause);
    check_eq("pause_running", 32'(running[0]), 32'd0);
    command(0, OpStep);
    check_eq("steppend_ready", 32'(cmd_ready[0]), 32'd0);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = OpRun;
    tick();
    check_eq("steppend_ready_hold", 32'(cmd_ready[0]), 32'd0);
    check_eq("steppend_run_dropped", 32'(running[0]), 32'd0);
    pulse(0);
    check_eq("step_offset", 32'(offset[0]), 32'd4);
    check_eq("step_upd", 32'(upd[0]), 32'd1);
    check_eq("step_paused", 32'(running[0]), 32'd0);
    check_eq("step_ready_back", 32'(cmd_ready[0]), 32'd1);
    tick();
    cmd_valid[0] = 1'b0;
    check_eq("run_after_step", 32'(running[0]), 32'd1);
    check_eq("step_frame_cnt", 32'(frame_cnt[0]), 32'd10);

    // REWIND coinciding with an advancing pulse
    pulse(0);
    check_eq("pre_rewind_offset", 32'(offset[0]), 32'd4);
    vblank[0]    = 1'b1;
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = OpRewind;
    tick();
    vblank[0]    = 1'b0;
    cmd_valid[0] = 1'b0;
    check_eq("rewind_offset", 32'(offset[0]), 32'd0);
    check_eq("rewind_upd", 32'(upd[0]), 32'd1);
    check_eq("rewind_running", 32'(running[0]), 32'd1);
    check_eq("rewind_frame_cnt", 32'(frame_cnt[0]), 32'd12);
    pulse(0);
    check_eq("rewind_div_clr", 32'(offset[0]), 32'd0);
    check_eq("rewind_div_clr_upd", 32'(upd[0]), 32'd0);
    pulse(0);
    check_eq("rewind_then_adv", 32'(offset[0]), 32'd1);

    // Reset while a step is armed
    command(0, OpPause);
    command(0, OpStep);
    check_eq("armed_ready", 32'(cmd_ready[0]), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_ready_low", 32'(cmd_ready[0]), 32'd0);
    tick();
    rst = 1'b0;
    check_eq("rst2_running", 32'(running[0]), 32'd0);
    check_eq("rst2_offset", 32'(offset[0]), 32'd0);
    check_eq("rst2_frame_cnt", 32'(frame_cnt[0]), 32'd0);
    #1;
    check_eq("rst2_ready", 32'(cmd_ready[0]), 32'd1);
    pulse(0);
    check_eq("rst2_no_adv", 32'(offset[0]), 32'd0);
    check_eq("rst2_no_upd", 32'(upd[0]), 32'd0);
    check_eq("rst2_frame_cnt1", 32'(frame_cnt[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
